local_pattern_table: RTL and testbench

LOCAL_PATTERN_TABLE -- requirements
Module: local_pattern_table

---
 rtl/bp_pkg.sv | 17 +
 rtl/bp_sat_ctr.sv | 23 ++
 rtl/local_pattern_table.sv | 81 ++++++++
 tb/tb_local_pattern_table.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions used by the local history table (LHT)
// and the local pattern table.
//   HIST_W   : local-history width, also the pattern-table index width
//   ctr_t    : 2-bit saturating counter type
//   SNT..ST  : counter encodings, strongly not-taken .. strongly taken
package bp_pkg;

  localparam int HIST_W = 5;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter.
// Ports:
//   cur   : current counter value
//   taken : resolved branch outcome (1 = taken)
//   nxt   : counter value after the update
module bp_sat_ctr
  import bp_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/local_pattern_table.sv
// Local pattern table: one 2-bit saturating counter per history pattern.
// A lookup is registered (result one cycle after pred_req); an update
// writes the counter at the closing edge and is bypassed into a lookup of
// the same index in the same cycle. The table is held in flops so a single
// reset cycle returns every entry to CTR_INIT.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   pred_req, pred_hist      : lookup request and index
//   upd_valid, upd_hist      : resolved branch and the index it used
//   upd_taken                : actual outcome
//   upd_pred_taken           : direction that was predicted for it
//   pred_valid               : lookup result valid (one cycle after pred_req)
//   pred_taken, pred_ctr     : predicted direction and counter; held when idle
//   mispred_cnt              : saturating count of mispredicted updates
module local_pattern_table
  import bp_pkg::*;
#(
  parameter int   HIST_W      = bp_pkg::HIST_W,
  parameter int   NUM_ENTRIES = 2 ** HIST_W,
  parameter ctr_t CTR_INIT    = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_req,
  input  logic [HIST_W-1:0] pred_hist,
  input  logic              upd_valid,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [1:0]        pred_ctr,
  output logic [15:0]       mispred_cnt
);

  ctr_t table_q [NUM_ENTRIES];

  ctr_t upd_cur;
  ctr_t upd_next;
  ctr_t lookup_val;
  logic mispredict;

  assign upd_cur = table_q[upd_hist];

  // Single shared next-state instance: only one update per cycle.
  bp_sat_ctr u_sat_ctr (
    .cur   (upd_cur),
    .taken (upd_taken),
    .nxt   (upd_next)
  );

  // Same-index update in the same cycle: the lookup sees the post-update value.
  always_comb begin
    lookup_val = table_q[pred_hist];
    if (upd_valid && (upd_hist == pred_hist)) lookup_val = upd_next;
  end

  assign mispredict = upd_valid && (upd_taken != upd_pred_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= CTR_INIT;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_ctr    <= 2'b00;
      mispred_cnt <= 16'h0000;
    end else begin
      if (upd_valid) table_q[upd_hist] <= upd_next;

      pred_valid <= pred_req;
      if (pred_req) begin
        pred_ctr   <= lookup_val;
        pred_taken <= lookup_val[1];
      end

      if (mispredict && (mispred_cnt != 16'hFFFF))
        mispred_cnt <= mispred_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_local_pattern_table.sv
module tb_local_pattern_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_req;
  logic [4:0]  pred_hist;
  logic        upd_valid;
  logic [4:0]  upd_hist;
  logic        upd_taken;
  logic        upd_pred_taken;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_ctr;
  logic [15:0] mispred_cnt;

  int errors = 0;
  int checks = 0;

  local_pattern_table dut (
    .clk            (clk),
    .rst            (rst),
    .pred_req       (pred_req),
    .pred_hist      (pred_hist),
    .upd_valid      (upd_valid),
    .upd_hist       (upd_hist),
    .upd_taken      (upd_taken),
    .upd_pred_taken (upd_pred_taken),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_ctr       (pred_ctr),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pred_req       = 1'b0;
    pred_hist      = '0;
    upd_valid      = 1'b0;
    upd_hist       = '0;
    upd_taken      = 1'b0;
    upd_pred_taken = 1'b0;
  endtask

  task automatic do_update(input logic [4:0] idx, input logic taken, input logic ptaken);
    upd_valid      = 1'b1;
    upd_hist       = idx;
    upd_taken      = taken;
    upd_pred_taken = ptaken;
    step();
    idle_inputs();
  endtask

  task automatic lookup(input string tag, input logic [4:0] idx, input logic [1:0] exp_ctr);
    pred_req  = 1'b1;
    pred_hist = idx;
    step();
    idle_inputs();
    chk({tag, "_valid"}, {15'd0, pred_valid}, 16'd1);
    chk({tag, "_ctr"},   {14'd0, pred_ctr},   {14'd0, exp_ctr});
    chk({tag, "_taken"}, {15'd0, pred_taken}, {15'd0, exp_ctr[1]});
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_valid",   {15'd0, pred_valid}, 16'd0);
    chk("rst_ctr",     {14'd0, pred_ctr},   16'd0);
    chk("rst_taken",   {15'd0, pred_taken}, 16'd0);
    chk("rst_mispred", mispred_cnt,         16'd0);
    rst = 1'b0;

    // First cycle after reset: lookup of an untouched entry gives CTR_INIT.
    lookup("init_0a", 5'h0A, 2'b01);
    step();
    chk("idle_valid", {15'd0, pred_valid}, 16'd0);
    chk("idle_hold",  {14'd0, pred_ctr},   16'd1);

    // Saturate up at 3, then one step down.
    repeat (4) do_update(5'd3, 1'b1, 1'b1);
    lookup("sat_hi_3", 5'd3, 2'b11);
    do_update(5'd3, 1'b0, 1'b0);
    lookup("dec_3", 5'd3, 2'b10);

    // Saturate down at 0.
    repeat (3) do_update(5'd7, 1'b0, 1'b0);
    lookup("sat_lo_7", 5'd7, 2'b00);
    do_update(5'd7, 1'b0, 1'b0);
    lookup("sat_lo_hold_7", 5'd7, 2'b00);

    // Lookup and update to different indices in the same cycle.
    pred_req = 1'b1; pred_hist = 5'd3;
    upd_valid = 1'b1; upd_hist = 5'd7; upd_taken = 1'b1; upd_pred_taken = 1'b1;
    step();
    idle_inputs();
    chk("indep_ctr", {14'd0, pred_ctr}, 16'd2);
    lookup("indep_7", 5'd7, 2'b01);

    // Same-cycle bypass on idx 9.
    lookup("pre_9", 5'd9, 2'b01);
    pred_req = 1'b1; pred_hist = 5'd9;
    upd_valid = 1'b1; upd_hist = 5'd9; upd_taken = 1'b1; upd_pred_taken = 1'b1;
    step();
    idle_inputs();
    chk("bypass_ctr",   {14'd0, pred_ctr},   16'd2);
    chk("bypass_taken", {15'd0, pred_taken}, 16'd1);
    lookup("post_9", 5'd9, 2'b10);

    // Mispredict counting, then saturation from a forced preload.
    chk("mis_none", mispred_cnt, 16'd0);
    do_update(5'd20, 1'b1, 1'b0);
    do_update(5'd20, 1'b0, 1'b1);
    chk("mis_two", mispred_cnt, 16'd2);
    do_update(5'd20, 1'b1, 1'b1);
    chk("mis_correct", mispred_cnt, 16'd2);
    force dut.mispred_cnt = 16'hFFFE;
    step();
    release dut.mispred_cnt;
    #1;
    chk("mis_preload", mispred_cnt, 16'hFFFE);
    do_update(5'd21, 1'b1, 1'b0);
    chk("mis_ffff", mispred_cnt, 16'hFFFF);
    do_update(5'd21, 1'b0, 1'b1);
    do_update(5'd21, 1'b1, 1'b0);
    chk("mis_sat", mispred_cnt, 16'hFFFF);

    // Reset wins over a simultaneous lookup and update.
    rst = 1'b1;
    pred_req = 1'b1; pred_hist = 5'd1;
    upd_valid = 1'b1; upd_hist = 5'd1; upd_taken = 1'b1; upd_pred_taken = 1'b0;
    step();
    idle_inputs();
    rst = 1'b0;
    chk("rstpri_valid",   {15'd0, pred_valid}, 16'd0);
    chk("rstpri_mispred", mispred_cnt,         16'd0);
    lookup("rstpri_1", 5'd1, 2'b01);
    lookup("rstclr_3", 5'd3, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
